// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto one sram-like slave port.
// One transaction outstanding; data has priority, bounded by a streak limit.
module sram_like_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  output logic        arb_busy,
  output logic        arb_owner
);

  localparam logic [3:0] MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        wr, wr_nx;
  logic [1:0]  size, size_nx;
  logic [31:0] addr, addr_nx;
  logic [31:0] wdata, wdata_nx;
  logic [3:0]  streak, streak_nx;
  logic        grant_data;
  logic        in_req, in_wait, done;

  // inst only overtakes data once data has won MAX times in a row
  assign grant_data = data_req & ~(inst_req & (streak == MAX));

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    wr_nx     = wr;
    size_nx   = size;
    addr_nx   = addr;
    wdata_nx  = wdata;
    streak_nx = streak;
    unique case (state)
      IDLE: begin
        if (inst_req | data_req) begin
          state_nx = REQ;
          owner_nx = grant_data;
          if (grant_data) begin
            wr_nx    = data_wr;
            size_nx  = data_size;
            addr_nx  = data_addr;
            wdata_nx = data_wdata;
            if (!inst_req)
              streak_nx = 4'd0;
            else if (streak < MAX)
              streak_nx = streak + 4'd1;
          end else begin
            wr_nx     = inst_wr;
            size_nx   = inst_size;
            addr_nx   = inst_addr;
            wdata_nx  = inst_wdata;
            streak_nx = 4'd0;
          end
        end
      end
      REQ: begin
        if (s_addr_ok)
          state_nx = s_data_ok ? IDLE : WAIT;
      end
      WAIT: begin
        if (s_data_ok)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      owner  <= 1'b0;
      wr     <= 1'b0;
      size   <= 2'd0;
      addr   <= 32'd0;
      wdata  <= 32'd0;
      streak <= 4'd0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      wr     <= wr_nx;
      size   <= size_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      streak <= streak_nx;
    end
  end

  assign in_req  = (state == REQ);
  assign in_wait = (state == WAIT);
  assign done    = (in_req & s_addr_ok & s_data_ok)
                 | (in_wait & s_data_ok);

  assign s_req   = in_req;
  assign s_wr    = wr;
  assign s_size  = size;
  assign s_addr  = addr;
  assign s_wdata = wdata;

  assign inst_addr_ok = in_req & s_addr_ok & ~owner;
  assign data_addr_ok = in_req & s_addr_ok & owner;
  assign inst_data_ok = done & ~owner;
  assign data_data_ok = done & owner;
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;

  assign arb_busy  = in_req | in_wait;
  assign arb_owner = owner;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Random two-master traffic against a transaction-level arbitration
// model; grants and completions are checked by a scoreboard monitor.
module tb_sram_like_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic [31:0] s_rdata = 0;
  logic        s_addr_ok = 0, s_data_ok = 0;
  wire  [31:0] inst_rdata, data_rdata, s_addr, s_wdata;
  wire         inst_addr_ok, inst_data_ok;
  wire         data_addr_ok, data_data_ok;
  wire         s_req, s_wr, arb_busy, arb_owner;
  wire  [1:0]  s_size;

  sram_like_arbiter #(.MAX_STREAK(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t exp_q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     i_prob = 0;
  int     d_prob = 0;
  bit     mon_en = 0;
  bit     sl_hold = 0;
  bit     sl_dok_valid = 0;
  int     sl_st = 0;
  bit     m_busy = 0;
  int     m_streak = 0;
  int     n_data_grants = 0;
  int     n_inst_grants = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, " s_req"}, 32'(s_req), 0);
    chk({tag, " s_wr"}, 32'(s_wr), 0);
    chk({tag, " s_size"}, 32'(s_size), 0);
    chk({tag, " s_addr"}, s_addr, 0);
    chk({tag, " s_wdata"}, s_wdata, 0);
    chk({tag, " addr_ok"}, 32'({inst_addr_ok, data_addr_ok}), 0);
    chk({tag, " data_ok"}, 32'({inst_data_ok, data_data_ok}), 0);
    chk({tag, " arb_busy"}, 32'(arb_busy), 0);
    chk({tag, " arb_owner"}, 32'(arb_owner), 0);
  endtask

  // instruction master: holds its request until addr_ok
  initial begin
    logic ack, rs;
    forever begin
      @(negedge clk);
      ack = inst_addr_ok;
      @(posedge clk);
      rs = resetn;
      #1;
      if (!rs) inst_req = 0;
      else if (!inst_req || ack) begin
        if (int'($urandom_range(0, 7)) < i_prob) begin
          inst_req   = 1;
          inst_wr    = 1'($urandom);
          inst_size  = 2'($urandom);
          inst_addr  = $urandom;
          inst_wdata = $urandom;
        end else inst_req = 0;
      end
    end
  end

  // data master
  initial begin
    logic ack, rs;
    forever begin
      @(negedge clk);
      ack = data_addr_ok;
      @(posedge clk);
      rs = resetn;
      #1;
      if (!rs) data_req = 0;
      else if (!data_req || ack) begin
        if (int'($urandom_range(0, 7)) < d_prob) begin
          data_req   = 1;
          data_wr    = 1'($urandom);
          data_size  = 2'($urandom);
          data_addr  = $urandom;
          data_wdata = $urandom;
        end else data_req = 0;
      end
    end
  end

  // slave: random addr/data latency, spurious data_ok when idle
  initial begin
    logic rs;
    int   cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      rs = resetn;
      #1;
      if (!rs) begin
        sl_st = 0;
        s_addr_ok = 0;
        s_data_ok = 0;
        sl_dok_valid = 0;
      end else begin
        if (sl_st == 1 && s_addr_ok) begin
          sl_st = s_data_ok ? 0 : 2;
          cnt = $urandom_range(0, 4);
        end else if (sl_st == 2 && sl_dok_valid) sl_st = 0;
        s_addr_ok = 0;
        s_data_ok = 0;
        sl_dok_valid = 0;
        s_rdata = $urandom;
        if (sl_st == 0 && s_req) begin
          sl_st = 1;
          cnt = $urandom_range(0, 3);
        end
        if (sl_st == 0) begin
          s_data_ok = ($urandom_range(0, 7) == 0);
        end else if (sl_st == 1) begin
          if (cnt == 0) begin
            s_addr_ok = 1;
            if ($urandom_range(0, 2) == 0) begin
              s_data_ok = 1;
              sl_dok_valid = 1;
            end
          end else begin
            cnt--;
            s_data_ok = ($urandom_range(0, 3) == 0);
          end
        end else begin
          if (cnt == 0 && !sl_hold) begin
            s_data_ok = 1;
            sl_dok_valid = 1;
          end else if (cnt > 0) cnt--;
        end
      end
    end
  end

  // reference model: port free -> pick a winner from pending requests
  initial begin
    grant_t g;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_busy = 0;
        m_streak = 0;
        exp_q.delete();
      end else if (m_busy) begin
        if (sl_dok_valid) m_busy = 0;
      end else if (inst_req || data_req) begin
        m_busy = 1;
        if (data_req && !(inst_req && m_streak == MAX)) begin
          g = '{1'b1, data_wr, data_size, data_addr, data_wdata};
          m_streak = inst_req ? ((m_streak < MAX) ? m_streak + 1 : MAX)
                              : 0;
          n_data_grants++;
        end else begin
          g = '{1'b0, inst_wr, inst_size, inst_addr, inst_wdata};
          m_streak = 0;
          n_inst_grants++;
        end
        exp_q.push_back(g);
      end
    end
  end

  // monitor / scoreboard
  initial begin
    grant_t g;
    logic   cur_owner;
    int     wait_cnt;
    cur_owner = 0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("arb_busy", 32'(arb_busy), 32'(m_busy));
        if (s_addr_ok) begin
          chk("s_req at addr_ok", 32'(s_req), 1);
          if (exp_q.size() == 0) begin
            chk("unexpected grant", 1, 0);
          end else begin
            g = exp_q.pop_front();
            cur_owner = g.owner;
            wait_cnt = 0;
            chk("arb_owner", 32'(arb_owner), 32'(g.owner));
            chk("s_wr", 32'(s_wr), 32'(g.wr));
            chk("s_size", 32'(s_size), 32'(g.size));
            chk("s_addr", s_addr, g.addr);
            chk("s_wdata", s_wdata, g.wdata);
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(!g.owner));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(g.owner));
          end
        end else begin
          chk("idle addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
        end
        if (sl_dok_valid) begin
          chk("inst_data_ok", 32'(inst_data_ok), 32'(!cur_owner));
          chk("data_data_ok", 32'(data_data_ok), 32'(cur_owner));
          chk("inst_rdata", inst_rdata, s_rdata);
          chk("data_rdata", data_rdata, s_rdata);
        end else begin
          chk("idle data_ok", 32'({inst_data_ok, data_data_ok}), 0);
        end
        if (exp_q.size() > 0) wait_cnt++;
        else wait_cnt = 0;
        if (wait_cnt > 64) begin
          chk("grant timeout", 1, 0);
          exp_q.delete();
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    zero_chk("reset");
    resetn = 1;
    mon_en = 1;
    i_prob = 4;
    d_prob = 4;
    repeat (1500) @(negedge clk);
    i_prob = 8;
    d_prob = 8;
    repeat (800) @(negedge clk);
    chk("streak ratio", 32'(n_data_grants >= 4 * n_inst_grants / 2), 1);
    i_prob = 3;
    d_prob = 6;
    repeat (200) @(negedge clk);
    sl_hold = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sl_st == 2) found = 1;
    end
    chk("reach wait", 32'(found), 1);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    sl_hold = 0;
    zero_chk("mid reset");
    repeat (500) @(negedge clk);
    i_prob = 0;
    d_prob = 0;
    repeat (100) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 0);
    chk("grants seen", 32'(n_inst_grants > 10 && n_data_grants > 10), 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4, meaning: max consecutive data grants while inst waits (legal range 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset; synchronous, active-low.
REQ-004 inst_req/inst_wr  input  1/1;  inst_size  input  2;  inst_addr/inst_wdata  input  32/32  (instruction master request).
REQ-005 inst_rdata  output  32;  inst_addr_ok/inst_data_ok  output  1/1  (instruction master response).
REQ-006 data_req/data_wr  input  1/1;  data_size  input  2;  data_addr/data_wdata  input  32/32  (data master request).
REQ-007 data_rdata  output  32;  data_addr_ok/data_data_ok  output  1/1  (data master response).
REQ-008 s_req/s_wr  output  1/1;  s_size  output  2;  s_addr/s_wdata  output  32/32  (shared slave port request).
REQ-009 s_rdata  input  32;  s_addr_ok/s_data_ok  input  1/1  (shared slave response).
REQ-010 arb_busy  output  1  high in REQ or WAIT; arb_owner  output  1  latched owner (1=data, 0=inst).

Function
REQ-011 All ports SHALL follow sram-like protocol: master holds req and request fields stable until addr_ok; exactly one data_ok per accepted request.
REQ-012 FSM SHALL have states IDLE, REQ, WAIT; at most one transaction outstanding on slave port.
REQ-013 IDLE: if any master req high, SHALL latch owner plus owner's wr/size/addr/wdata into registers and move to REQ next cycle; else stay IDLE.
REQ-014 Owner selection: data wins over inst, except inst SHALL win when inst_req high and streak counter == MAX_STREAK.
REQ-015 Streak counter (4 bits) SHALL increment on each data grant made while inst_req high, clear on any inst grant, clear on data grant with inst_req low; saturates at MAX_STREAK.
REQ-016 REQ: s_req=1, s_wr/s_size/s_addr/s_wdata driven from latched registers only; no combinational path from master request fields to slave outputs.
REQ-017 REQ: s_addr_ok SHALL be forwarded only to owner's addr_ok same cycle (combinational); non-owner addr_ok=0.
REQ-018 REQ with s_addr_ok=1 and s_data_ok=0 -> WAIT; with both =1 -> IDLE, owner's data_ok pulsed same cycle.
REQ-019 WAIT: s_req=0; s_data_ok forwarded only to owner's data_ok same cycle; on s_data_ok -> IDLE.
REQ-020 inst_rdata and data_rdata SHALL both equal s_rdata combinationally; validity qualified only by respective data_ok.
REQ-021 s_data_ok in IDLE, or in REQ without s_addr_ok, SHALL be ignored (no master data_ok, no state change).
REQ-022 Non-owner master request stays pending untouched; earliest regrant is IDLE cycle after completion (min 2-cycle gap between s_req assertions of back-to-back transactions: WAIT->IDLE->REQ).
REQ-023 Minimum latency: master req (IDLE) -> s_req 1 cycle; s_addr_ok -> master addr_ok 0 cycles; s_data_ok -> master data_ok 0 cycles.
REQ-024 Simultaneous inst_req and data_req in IDLE resolved per REQ-014 in same cycle; no cycle lost.

Reset
REQ-025 resetn=0 at clock edge SHALL force IDLE, streak=0, latched owner/wr/size/addr/wdata=0, regardless of current state.
REQ-026 During/after reset: s_req=0, all master addr_ok/data_ok=0, arb_busy=0, arb_owner=0, s_wr/s_size/s_addr/s_wdata=0.
REQ-027 Reset mid-transaction SHALL abandon it silently; no data_ok generated for abandoned request; slave reset by same resetn.

Verification
REQ-028 Single inst read addr 0xBFC00000, slave addr_ok 2 cycles after s_req, data_ok 3 cycles later rdata 0x3C08BFAF -> inst_addr_ok/inst_data_ok one pulse each, inst_rdata=0x3C08BFAF, data_* silent.
REQ-029 inst_req and data_req (write 0x1234_5678 to 0x8000_0010, size 2) same cycle -> data granted first, s_addr=0x80000010, s_wdata=0x12345678, inst served after data_data_ok, arb_owner 1 then 0.
REQ-030 data_req held continuously with inst_req high, MAX_STREAK=4 -> exactly 4 data grants then 1 inst grant, pattern repeats; streak returns to 0 after inst grant.
REQ-031 Slave returns s_addr_ok and s_data_ok in same REQ cycle -> owner gets addr_ok and data_ok same cycle, FSM returns IDLE next cycle, no WAIT.
REQ-032 Spurious s_data_ok in IDLE, then resetn=0 for 1 cycle while in WAIT -> no master data_ok either time; after reset all outputs 0, arb_busy=0, next request served normally.
